// File: rtl/bcd_clock_ctrl_if.sv
// Signal bundle between the button front-end / clock datapath and bcd_clock_ctrl.
// Optional alarm signals exist only when BCD_CLOCK_ALARM_EN is defined.
interface bcd_clock_ctrl_if;
  // Buttons are single-cycle pulses with no ready/ack; tick_o and load_o are
  // single-cycle strobes that the datapath must act on in the cycle they are high.
  logic       mode_btn;
  logic       inc_btn;
  logic [7:0] cur_hh;
  logic [7:0] cur_mm;
  logic [7:0] cur_ss;
  logic       cur_pm;
  logic       tick_o;
  logic       load_o;
  logic [7:0] load_hh;
  logic [7:0] load_mm;
  logic       load_pm;
  logic [1:0] state_o;
  logic       blink_o;
`ifdef BCD_CLOCK_ALARM_EN
  logic [7:0] al_hh;
  logic [7:0] al_mm;
  logic       al_pm;
  logic       alarm_clr;
  logic       alarm_o;

  modport master (
    output mode_btn, inc_btn, cur_hh, cur_mm, cur_ss, cur_pm,
    output al_hh, al_mm, al_pm, alarm_clr,
    input  tick_o, load_o, load_hh, load_mm, load_pm, state_o, blink_o, alarm_o
  );
  modport slave (
    input  mode_btn, inc_btn, cur_hh, cur_mm, cur_ss, cur_pm,
    input  al_hh, al_mm, al_pm, alarm_clr,
    output tick_o, load_o, load_hh, load_mm, load_pm, state_o, blink_o, alarm_o
  );
`else
  modport master (
    output mode_btn, inc_btn, cur_hh, cur_mm, cur_ss, cur_pm,
    input  tick_o, load_o, load_hh, load_mm, load_pm, state_o, blink_o
  );
  modport slave (
    input  mode_btn, inc_btn, cur_hh, cur_mm, cur_ss, cur_pm,
    output tick_o, load_o, load_hh, load_mm, load_pm, state_o, blink_o
  );
`endif
endinterface

// File: rtl/bcd_clock_ctrl.sv
// 12-hour BCD clock sequencer: 1 Hz prescaler plus mode/inc time-set FSM.
// Define BCD_CLOCK_ALARM_EN to add the sticky alarm comparator.
module bcd_clock_ctrl #(
  parameter int PRESCALE = 100
) (
  input logic            clk,
  input logic            reset,
  bcd_clock_ctrl_if.slave bus
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            blink_q, blink_d;
  logic            load_q;
  logic [7:0]      hh_q, hh_d, mm_q, mm_d;
  logic            pm_q, pm_d;
  logic            wrap;
  logic            tick;
  logic            editing;

  function automatic logic [7:0] hr_inc(input logic [7:0] h);
    if (h == 8'h12)        return 8'h01;
    else if (h[3:0] == 4'h9) return {h[7:4] + 4'h1, 4'h0};
    else                   return {h[7:4], h[3:0] + 4'h1};
  endfunction

  function automatic logic [7:0] min_inc(input logic [7:0] m);
    if (m == 8'h59)        return 8'h00;
    else if (m[3:0] == 4'h9) return {m[7:4] + 4'h1, 4'h0};
    else                   return {m[7:4], m[3:0] + 4'h1};
  endfunction

  assign wrap    = (cnt_q == LAST);
  assign tick    = wrap && (state_q == RUN);
  assign editing = (state_q == SET_HR) || (state_q == SET_MIN);

  always_comb begin
    state_d = state_q;
    cnt_d   = wrap ? '0 : cnt_q + CW'(1);
    blink_d = blink_q;
    hh_d    = hh_q;
    mm_d    = mm_q;
    pm_d    = pm_q;
    // mode has priority: an inc arriving with mode in the same cycle is dropped
    case (state_q)
      RUN: begin
        blink_d = 1'b0;
        if (bus.mode_btn) begin
          state_d = SET_HR;
          hh_d    = bus.cur_hh;
          mm_d    = bus.cur_mm;
          pm_d    = bus.cur_pm;
        end
      end
      SET_HR: begin
        if (wrap) blink_d = ~blink_q;
        if (bus.mode_btn) begin
          state_d = SET_MIN;
        end else if (bus.inc_btn) begin
          hh_d = hr_inc(hh_q);
          if (hh_q == 8'h11) pm_d = ~pm_q;
        end
      end
      SET_MIN: begin
        if (wrap) blink_d = ~blink_q;
        if (bus.mode_btn)     state_d = COMMIT;
        else if (bus.inc_btn) mm_d = min_inc(mm_q);
      end
      COMMIT: begin
        state_d = RUN;
        cnt_d   = '0;
        blink_d = 1'b0;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      blink_q <= 1'b0;
      load_q  <= 1'b0;
      hh_q    <= 8'h12;
      mm_q    <= 8'h00;
      pm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
      load_q  <= (state_d == COMMIT);
      hh_q    <= hh_d;
      mm_q    <= mm_d;
      pm_q    <= pm_d;
    end
  end

  assign bus.tick_o  = tick;
  assign bus.load_o  = load_q;
  assign bus.load_hh = hh_q;
  assign bus.load_mm = mm_q;
  assign bus.load_pm = pm_q;
  assign bus.state_o = state_q;
  assign bus.blink_o = blink_q && editing;

`ifdef BCD_CLOCK_ALARM_EN
  logic alarm_q;
  logic al_match;
  logic al_clear;

  assign al_match = (bus.cur_hh == bus.al_hh) && (bus.cur_mm == bus.al_mm) &&
                    (bus.cur_pm == bus.al_pm) && (bus.cur_ss == 8'h00);
  assign al_clear = bus.alarm_clr || (bus.inc_btn && (state_q == RUN));

  always_ff @(posedge clk) begin
    if (reset)              alarm_q <= 1'b0;
    else if (al_clear)      alarm_q <= 1'b0;
    else if (tick && al_match) alarm_q <= 1'b1;
  end

  assign bus.alarm_o = alarm_q;
`else
  logic unused_ss;
  assign unused_ss = ^bus.cur_ss;
`endif

endmodule

// File: tb/tb_bcd_clock_ctrl.sv
// Directed self-checking bench for bcd_clock_ctrl with PRESCALE=4.
// Alarm scenarios are compiled in when BCD_CLOCK_ALARM_EN is defined.
module tb_bcd_clock_ctrl;
  localparam int PRESCALE = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   tick_cnt = 0;
  int   load_cnt = 0;

  bcd_clock_ctrl_if bus();

  bcd_clock_ctrl #(.PRESCALE(PRESCALE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // strobe counters sampled mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (bus.tick_o === 1'b1) tick_cnt++;
    if (bus.load_o === 1'b1) load_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic m, input logic i);
    bus.mode_btn = m;
    bus.inc_btn  = i;
    step();
    bus.mode_btn = 1'b0;
    bus.inc_btn  = 1'b0;
  endtask

  task automatic set_cur(input logic [7:0] hh, input logic [7:0] mm, input logic pm,
                         input logic [7:0] ss);
    bus.cur_hh = hh;
    bus.cur_mm = mm;
    bus.cur_pm = pm;
    bus.cur_ss = ss;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++; if (bus.state_o !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", bus.state_o); end
    checks++; if (bus.tick_o !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", bus.tick_o); end
    checks++; if (bus.load_o !== 1'b0) begin errors++; $display("FAIL reset_load: got %b expected 0", bus.load_o); end
    checks++; if (bus.load_hh !== 8'h12) begin errors++; $display("FAIL reset_hh: got %h expected 12", bus.load_hh); end
    checks++; if (bus.load_mm !== 8'h00) begin errors++; $display("FAIL reset_mm: got %h expected 00", bus.load_mm); end
    checks++; if (bus.load_pm !== 1'b0) begin errors++; $display("FAIL reset_pm: got %b expected 0", bus.load_pm); end
    checks++; if (bus.blink_o !== 1'b0) begin errors++; $display("FAIL reset_blink: got %b expected 0", bus.blink_o); end
    reset = 1'b0;
  endtask

  task automatic test_idle_ticks();
    int l0;
    logic exp_tick;
    l0 = load_cnt;
    for (int i = 1; i <= 12; i++) begin
      exp_tick = (i % 4 == 0);
      checks++; if (bus.tick_o !== exp_tick) begin errors++; $display("FAIL idle_tick c%0d: got %b expected %b", i, bus.tick_o, exp_tick); end
      checks++; if (bus.state_o !== 2'd0) begin errors++; $display("FAIL idle_state c%0d: got %0d expected 0", i, bus.state_o); end
      step();
    end
    checks++; if (load_cnt !== l0) begin errors++; $display("FAIL idle_load: got %0d loads expected 0", load_cnt - l0); end
  endtask

  task automatic test_set_sequence();
    int t0, l0;
    set_cur(8'h11, 8'h58, 1'b0, 8'h00);
    l0 = load_cnt;
    pulse(1'b1, 1'b0);
    t0 = tick_cnt;
    checks++; if (bus.state_o !== 2'd1) begin errors++; $display("FAIL seq_state1: got %0d expected 1", bus.state_o); end
    checks++; if ({bus.load_hh, bus.load_mm, 7'd0, bus.load_pm} !== 24'h115800) begin errors++; $display("FAIL seq_capture: got %h:%h pm%b expected 11:58 pm0", bus.load_hh, bus.load_mm, bus.load_pm); end
    pulse(1'b0, 1'b1);
    checks++; if (bus.load_hh !== 8'h12 || bus.load_pm !== 1'b1) begin errors++; $display("FAIL seq_hr_inc: got %h pm%b expected 12 pm1", bus.load_hh, bus.load_pm); end
    pulse(1'b1, 1'b0);
    checks++; if (bus.state_o !== 2'd2) begin errors++; $display("FAIL seq_state2: got %0d expected 2", bus.state_o); end
    repeat (3) pulse(1'b0, 1'b1);
    checks++; if (bus.load_mm !== 8'h01) begin errors++; $display("FAIL seq_min_inc: got %h expected 01", bus.load_mm); end
    pulse(1'b1, 1'b0);
    checks++; if (bus.state_o !== 2'd3) begin errors++; $display("FAIL seq_state3: got %0d expected 3", bus.state_o); end
    checks++; if (bus.load_o !== 1'b1) begin errors++; $display("FAIL seq_load_hi: got %b expected 1", bus.load_o); end
    checks++; if ({bus.load_hh, bus.load_mm, 7'd0, bus.load_pm} !== 24'h120101) begin errors++; $display("FAIL seq_load_val: got %h:%h pm%b expected 12:01 pm1", bus.load_hh, bus.load_mm, bus.load_pm); end
    step();
    checks++; if (bus.state_o !== 2'd0) begin errors++; $display("FAIL seq_state0: got %0d expected 0", bus.state_o); end
    checks++; if (bus.load_o !== 1'b0) begin errors++; $display("FAIL seq_load_lo: got %b expected 0", bus.load_o); end
    checks++; if (tick_cnt !== t0) begin errors++; $display("FAIL seq_no_tick: got %0d ticks expected 0", tick_cnt - t0); end
    checks++; if (load_cnt - l0 !== 1) begin errors++; $display("FAIL seq_one_load: got %0d loads expected 1", load_cnt - l0); end
  endtask

  task automatic test_blink();
    logic exp_blink;
    reset = 1'b1;
    step();
    reset = 1'b0;
    pulse(1'b1, 1'b0);
    for (int k = 0; k <= 7; k++) begin
      exp_blink = ((k + 1) / 4) % 2 == 1;
      checks++; if (bus.blink_o !== exp_blink) begin errors++; $display("FAIL blink k%0d: got %b expected %b", k, bus.blink_o, exp_blink); end
      if (k < 7) step();
    end
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    checks++; if (bus.blink_o !== 1'b0) begin errors++; $display("FAIL blink_commit: got %b expected 0", bus.blink_o); end
    step();
    // prescaler restarts from 0 after COMMIT, so the first tick is on RUN cycle 4
    for (int i = 1; i <= 4; i++) begin
      checks++; if (bus.tick_o !== (i == 4)) begin errors++; $display("FAIL commit_prescale c%0d: got %b expected %b", i, bus.tick_o, (i == 4)); end
      step();
    end
  endtask

  task automatic test_hour_wrap();
    set_cur(8'h12, 8'h00, 1'b1, 8'h00);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    checks++; if (bus.load_hh !== 8'h01 || bus.load_pm !== 1'b1) begin errors++; $display("FAIL hr_12_to_01: got %h pm%b expected 01 pm1", bus.load_hh, bus.load_pm); end
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    step();
    set_cur(8'h09, 8'h45, 1'b0, 8'h00);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    checks++; if (bus.load_hh !== 8'h10 || bus.load_pm !== 1'b0) begin errors++; $display("FAIL hr_09_to_10: got %h pm%b expected 10 pm0", bus.load_hh, bus.load_pm); end
    pulse(1'b0, 1'b1);
    checks++; if (bus.load_hh !== 8'h11 || bus.load_pm !== 1'b0) begin errors++; $display("FAIL hr_10_to_11: got %h pm%b expected 11 pm0", bus.load_hh, bus.load_pm); end
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    step();
  endtask

  task automatic test_minute_wrap();
    set_cur(8'h03, 8'h09, 1'b0, 8'h00);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    checks++; if (bus.load_mm !== 8'h10) begin errors++; $display("FAIL min_09_to_10: got %h expected 10", bus.load_mm); end
    pulse(1'b1, 1'b0);
    step();
    set_cur(8'h05, 8'h59, 1'b0, 8'h00);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    checks++; if (bus.load_mm !== 8'h00 || bus.load_hh !== 8'h05) begin errors++; $display("FAIL min_59_to_00: got %h:%h expected 05:00", bus.load_hh, bus.load_mm); end
    // mode+inc together, then mode held into COMMIT where it must be ignored
    bus.mode_btn = 1'b1;
    bus.inc_btn  = 1'b1;
    step();
    bus.inc_btn  = 1'b0;
    checks++; if (bus.state_o !== 2'd3 || bus.load_mm !== 8'h00) begin errors++; $display("FAIL mode_inc_same: got state %0d mm %h expected state 3 mm 00", bus.state_o, bus.load_mm); end
    step();
    bus.mode_btn = 1'b0;
    checks++; if (bus.state_o !== 2'd0) begin errors++; $display("FAIL mode_in_commit: got %0d expected 0", bus.state_o); end
    pulse(1'b0, 1'b1);
    checks++; if (bus.state_o !== 2'd0 || bus.load_mm !== 8'h00 || bus.load_hh !== 8'h05) begin errors++; $display("FAIL inc_in_run: got state %0d %h:%h expected 0 05:00", bus.state_o, bus.load_hh, bus.load_mm); end
  endtask

  task automatic test_reset_mid_edit();
    int l0;
    set_cur(8'h08, 8'h20, 1'b1, 8'h00);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    checks++; if (bus.state_o !== 2'd2 || bus.load_mm !== 8'h21) begin errors++; $display("FAIL mid_edit_setup: got state %0d mm %h expected 2 21", bus.state_o, bus.load_mm); end
    l0 = load_cnt;
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (bus.state_o !== 2'd0 || bus.load_o !== 1'b0) begin errors++; $display("FAIL mid_reset_state: got state %0d load %b expected 0 0", bus.state_o, bus.load_o); end
    checks++; if (bus.load_hh !== 8'h12 || bus.load_mm !== 8'h00 || bus.load_pm !== 1'b0) begin errors++; $display("FAIL mid_reset_regs: got %h:%h pm%b expected 12:00 pm0", bus.load_hh, bus.load_mm, bus.load_pm); end
    repeat (6) step();
    checks++; if (load_cnt !== l0) begin errors++; $display("FAIL mid_reset_noload: got %0d loads expected 0", load_cnt - l0); end
  endtask

`ifdef BCD_CLOCK_ALARM_EN
  task automatic wait_tick(input string name);
    int n;
    n = 0;
    while (bus.tick_o !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    checks++; if (bus.tick_o !== 1'b1) begin errors++; $display("FAIL %s_tick_timeout: got %b expected 1", name, bus.tick_o); end
  endtask

  task automatic test_alarm();
    bus.al_hh = 8'h07;
    bus.al_mm = 8'h30;
    bus.al_pm = 1'b0;
    set_cur(8'h07, 8'h30, 1'b0, 8'h01);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (bus.alarm_o !== 1'b0) begin errors++; $display("FAIL alarm_reset: got %b expected 0", bus.alarm_o); end
    wait_tick("al_ss");
    step();
    checks++; if (bus.alarm_o !== 1'b0) begin errors++; $display("FAIL alarm_ss_mismatch: got %b expected 0", bus.alarm_o); end
    bus.cur_ss = 8'h00;
    wait_tick("al_set");
    step();
    checks++; if (bus.alarm_o !== 1'b1) begin errors++; $display("FAIL alarm_set: got %b expected 1", bus.alarm_o); end
    bus.cur_ss = 8'h01;
    repeat (5) step();
    checks++; if (bus.alarm_o !== 1'b1) begin errors++; $display("FAIL alarm_sticky: got %b expected 1", bus.alarm_o); end
    bus.alarm_clr = 1'b1;
    step();
    bus.alarm_clr = 1'b0;
    checks++; if (bus.alarm_o !== 1'b0) begin errors++; $display("FAIL alarm_clr: got %b expected 0", bus.alarm_o); end
    bus.cur_ss = 8'h00;
    wait_tick("al_coinc");
    bus.alarm_clr = 1'b1;
    step();
    bus.alarm_clr = 1'b0;
    checks++; if (bus.alarm_o !== 1'b0) begin errors++; $display("FAIL alarm_clr_wins: got %b expected 0", bus.alarm_o); end
    wait_tick("al_inc");
    step();
    checks++; if (bus.alarm_o !== 1'b1) begin errors++; $display("FAIL alarm_reset2: got %b expected 1", bus.alarm_o); end
    pulse(1'b0, 1'b1);
    checks++; if (bus.alarm_o !== 1'b0) begin errors++; $display("FAIL alarm_inc_clr: got %b expected 0", bus.alarm_o); end
  endtask
`endif

  initial begin
    reset        = 1'b1;
    bus.mode_btn = 1'b0;
    bus.inc_btn  = 1'b0;
    set_cur(8'h12, 8'h00, 1'b0, 8'h00);
`ifdef BCD_CLOCK_ALARM_EN
    bus.al_hh     = 8'h00;
    bus.al_mm     = 8'h00;
    bus.al_pm     = 1'b0;
    bus.alarm_clr = 1'b0;
`endif
    test_reset();
    test_idle_ticks();
    test_set_sequence();
    test_blink();
    test_hour_wrap();
    test_minute_wrap();
    test_reset_mid_edit();
`ifdef BCD_CLOCK_ALARM_EN
    test_alarm();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
